proc_core: RTL and testbench

- Parametrised successor of the toy 16-bit CPU: multi-cycle core with configurable data width, address width and register count.
- Adds two-word instructions, a req/ready memory handshake with wait states, and a HALT state.
- Sits between the top-level memory model and debug/LED logic.
- Has one shared bus for instruction and data.

---
 rtl/proc_pkg.sv | 36 +++
 rtl/proc_if.sv | 22 ++
 rtl/proc_alu.sv | 31 +++
 rtl/proc_core.sv | 205 ++++++++++++++++++++
 tb/tb_proc_core.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for proc_core: opcodes, FSM state encoding and the
// instruction-length decode helper.
package proc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_LDA = 4'hA;
    localparam logic [3:0] OP_STA = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_FETCH_IMM = 3'd1,
        S_EXEC      = 3'd2,
        S_MEM       = 3'd3,
        S_HALT      = 3'd4
    } state_e;

    // Ops carrying a full-word immediate in the following memory word.
    function automatic logic is_two_word(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_LDA) || (op == OP_STA) ||
               (op == OP_JMP) || (op == OP_JZ)  || (op == OP_JC);
    endfunction

endpackage

// File: rtl/proc_if.sv
// Shared instruction/data bus between proc_core (master) and memory (slave).
interface proc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU for proc_core; flags are only meaningful for ADD..XOR.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              c_out,
    output logic              z_out
);

    always_comb begin
        result = a;
        c_out  = 1'b0;
        case (op)
            // The extra top bit is carry for ADD and borrow (a < b) for SUB.
            OP_ADD:  {c_out, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {c_out, result} = {1'b0, a} - {1'b0, b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = b;
            default: result = a;
        endcase
        z_out = (result == '0);
    end

endmodule

// File: rtl/proc_core.sv
// Multi-cycle core on a shared req/ready bus. Defining PROC_PERF_EN adds
// the perf_cycles / perf_retired counters.
module proc_core
    import proc_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter int              NREGS    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    proc_if.master            bus,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic              c_flag,
    output logic              z_flag
`ifdef PROC_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
`endif
);

    state_e            state_q, state_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:4]       ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              c_q, c_d, z_q, z_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [3:0]        op, rd, rs;
    logic [DATA_W-1:0] rd_val, rs_val, alu_res, wr_data;
    logic              alu_c, alu_z, wr_en;
    logic              req_c, we_c;
    logic [ADDR_W-1:0] addr_c;

    assign op = ir_q[15:12];
    assign rd = ir_q[11:8];
    assign rs = ir_q[7:4];

    function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
        logic [ADDR_W+DATA_W-1:0] ext;
        ext = {{ADDR_W{1'b0}}, v};
        return ext[ADDR_W-1:0];
    endfunction

    // Out-of-range register indices read as zero.
    always_comb begin
        rd_val = '0;
        rs_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd == 4'(i)) rd_val = regs_q[i];
            if (rs == 4'(i)) rs_val = regs_q[i];
        end
    end

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (rd_val),
        .b      (rs_val),
        .result (alu_res),
        .c_out  (alu_c),
        .z_out  (alu_z)
    );

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        c_d     = c_q;
        z_d     = z_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = pc_q;
        wr_en   = 1'b0;
        wr_data = alu_res;
        case (state_q)
            // run_q keeps the bus idle for the first cycle after reset.
            S_FETCH: if (run_q) begin
                req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata[15:4];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = is_two_word(bus.mem_rdata[15:12]) ? S_FETCH_IMM : S_EXEC;
                end
            end
            S_FETCH_IMM: begin
                req_c = 1'b1;
                if (bus.mem_ready) begin
                    imm_d   = bus.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        wr_en = 1'b1;
                        c_d   = alu_c;
                        z_d   = alu_z;
                    end
                    OP_MOV: wr_en = 1'b1;
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = imm_q;
                    end
                    OP_LD, OP_ST, OP_LDA, OP_STA: state_d = S_MEM;
                    OP_JMP: pc_d = to_addr(imm_q);
                    OP_JZ:  if (z_q) pc_d = to_addr(imm_q);
                    OP_JC:  if (c_q) pc_d = to_addr(imm_q);
                    OP_HLT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                req_c = 1'b1;
                case (op)
                    OP_LD:   addr_c = to_addr(rs_val);
                    OP_ST:   begin addr_c = to_addr(rd_val); we_c = 1'b1; end
                    OP_LDA:  addr_c = to_addr(imm_q);
                    OP_STA:  begin addr_c = to_addr(imm_q); we_c = 1'b1; end
                    default: ;
                endcase
                if (bus.mem_ready) begin
                    wr_en   = !we_c;
                    wr_data = bus.mem_rdata;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase

        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (rd == 4'(i))) regs_d[i] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            pc_q    <= RESET_PC;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            pc_q    <= pc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_ff @(posedge clk) begin
        ir_q  <= ir_d;
        imm_q <= imm_d;
    end

    assign bus.mem_req   = req_c;
    assign bus.mem_we    = we_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = rs_val;
    assign halted        = (state_q == S_HALT);
    assign dbg_pc        = pc_q;
    assign c_flag        = c_q;
    assign z_flag        = z_q;

`ifdef PROC_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_retired_q, perf_retired_d;

    // An instruction retires when EXEC/MEM hands back to FETCH or enters HALT.
    always_comb begin
        perf_cycles_d  = perf_cycles_q + ((state_q != S_HALT) ? 32'd1 : 32'd0);
        perf_retired_d = perf_retired_q;
        if (((state_q == S_EXEC) || (state_q == S_MEM)) &&
            ((state_d == S_FETCH) || (state_d == S_HALT)))
            perf_retired_d = perf_retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q  <= '0;
            perf_retired_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_proc_core.sv
// Directed bench for proc_core: memory model with programmable wait states,
// a scoreboard of expected write beats and a bus-hold monitor.
module tb_proc_core;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted, c_flag, z_flag;
    logic [15:0] dbg_pc;
`ifdef PROC_PERF_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    int          total = 0;
    int          bad = 0;
    int          wait_cycles = 0;
    int          wcnt = 0;
    int          hcnt;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] mem [0:65535];
    logic [15:0] prog_q [$];
    wr_t         exp_q [$];
    logic        prev_wait = 1'b0;
    logic [32:0] prev_bus = '0;

    proc_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    proc_core #(.DATA_W(16), .ADDR_W(16), .NREGS(4), .RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .halted (halted),
        .dbg_pc (dbg_pc),
        .c_flag (c_flag),
        .z_flag (z_flag)
`ifdef PROC_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired)
`endif
    );

    always #5 clk = ~clk;

    assign bus.mem_ready = bus.mem_req && (wcnt >= wait_cycles);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (rst_n && bus.mem_req && bus.mem_we && bus.mem_ready)
            mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-beat scoreboard and bus-hold checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.mem_req && bus.mem_we && bus.mem_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL wr_unexpected: observed write %h<=%h expected none",
                       bus.mem_addr, bus.mem_wdata);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_beat", {bus.mem_addr, bus.mem_wdata}, e);
            end
        end
        if (rst_n && prev_wait && bus.mem_req)
            check("bus_hold", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, prev_bus);
        prev_wait = rst_n && bus.mem_req && !bus.mem_ready;
        prev_bus  = {bus.mem_addr, bus.mem_we, bus.mem_wdata};
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic begin_load(input int waits);
        @(negedge clk);
        rst_n = 1'b0;
        wait_cycles = waits;
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [15:0] base);
        for (int i = 0; i < prog_q.size(); i++) poke(base + 16'(i), prog_q[i]);
    endtask

    // Cycle 1 is the first cycle with mem_req high; returns the cycle halted is seen.
    task automatic run_to_halt(input int budget, output int cnt);
        cnt = 0;
        rst_n = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                cnt = 1;
                break;
            end
        end
        check("start_req", bus.mem_req, 1);
        for (int n = 0; n < budget && !halted; n++) begin
            @(negedge clk);
            cnt++;
        end
        check("halt_seen", halted, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", dbg_pc, 16'h0000);
        check("rst_c", c_flag, 0);
        check("rst_z", z_flag, 0);
`ifdef PROC_PERF_EN
        check("rst_perf_cyc", perf_cycles, 0);
        check("rst_perf_ret", perf_retired, 0);
`endif

        // LDI r0,5; LDI r1,3; ADD r0,r1; HLT
        begin_load(0);
        prog_q = '{16'h7000, 16'h0005, 16'h7100, 16'h0003, 16'h1010, 16'hF000};
        load_prog(16'h0000);
        run_to_halt(200, hcnt);
        check("p1_halt_cyc", hcnt, 11);
        check("p1_pc", dbg_pc, 16'h0006);
        check("p1_z", z_flag, 0);
        check("p1_c", c_flag, 0);

        // Same sum, stored to 0x80 to expose r0
        begin_load(0);
        prog_q = '{16'h7000, 16'h0005, 16'h7100, 16'h0003, 16'h1010,
                   16'hB000, 16'h0080, 16'hF000};
        load_prog(16'h0000);
        poke(16'h0080, 16'h0000);
        exp_q.push_back('{a: 16'h0080, d: 16'h0008});
        run_to_halt(200, hcnt);
        check("p2_sb_empty", exp_q.size(), 0);

        // 0xFFFF + 1 wraps, sets c and z; JC 0x20 taken
        begin_load(0);
        prog_q = '{16'h7000, 16'hFFFF, 16'h7100, 16'h0001, 16'h1010,
                   16'hE000, 16'h0020, 16'hF000};
        load_prog(16'h0000);
        prog_q = '{16'hB000, 16'h0081, 16'hF000};
        load_prog(16'h0020);
        exp_q.push_back('{a: 16'h0081, d: 16'h0000});
        run_to_halt(200, hcnt);
        check("p3_pc", dbg_pc, 16'h0023);
        check("p3_c", c_flag, 1);
        check("p3_z", z_flag, 1);
        check("p3_sb_empty", exp_q.size(), 0);

        // ST [r2],r3 then LD r1,[r2] round trip
        begin_load(0);
        prog_q = '{16'h7200, 16'h0040, 16'h7300, 16'hBEEF, 16'h9230, 16'h8120,
                   16'hB010, 16'h0082, 16'hF000};
        load_prog(16'h0000);
        poke(16'h0040, 16'h0000);
        exp_q.push_back('{a: 16'h0040, d: 16'hBEEF});
        exp_q.push_back('{a: 16'h0082, d: 16'hBEEF});
        run_to_halt(200, hcnt);
        check("p4_c", c_flag, 0);
        check("p4_z", z_flag, 0);
        check("p4_sb_empty", exp_q.size(), 0);

        // SUB borrow, XOR to zero, JZ 0x30 taken
        begin_load(0);
        prog_q = '{16'h7000, 16'h0003, 16'h7100, 16'h0005, 16'h2010, 16'hB000,
                   16'h0083, 16'h5110, 16'hB010, 16'h0084, 16'hD000, 16'h0030,
                   16'hF000};
        load_prog(16'h0000);
        poke(16'h0030, 16'hF000);
        exp_q.push_back('{a: 16'h0083, d: 16'hFFFE});
        exp_q.push_back('{a: 16'h0084, d: 16'h0000});
        run_to_halt(300, hcnt);
        check("p5_pc", dbg_pc, 16'h0031);
        check("p5_z", z_flag, 1);
        check("p5_c", c_flag, 0);
        check("p5_sb_empty", exp_q.size(), 0);

        // Register index beyond NREGS: LDI r5,7 dropped, MOV r0,r5 reads 0
        begin_load(0);
        prog_q = '{16'h7500, 16'h0007, 16'h6050, 16'hB000, 16'h0085, 16'hF000};
        load_prog(16'h0000);
        exp_q.push_back('{a: 16'h0085, d: 16'h0000});
        run_to_halt(200, hcnt);
        check("p6_halt_cyc", hcnt, 12);
        check("p6_sb_empty", exp_q.size(), 0);
`ifdef PROC_PERF_EN
        check("p6_perf_ret", perf_retired, 4);
        check("p6_perf_cyc", perf_cycles, 12);
`endif

        // Three wait states on every access: LDA then STA
        begin_load(3);
        prog_q = '{16'hA100, 16'h0090, 16'hB010, 16'h0091, 16'hF000};
        load_prog(16'h0000);
        poke(16'h0090, 16'h1234);
        exp_q.push_back('{a: 16'h0091, d: 16'h1234});
        run_to_halt(400, hcnt);
        check("p7_halt_cyc", hcnt, 32);
        check("p7_sb_empty", exp_q.size(), 0);

        // Reset while a store waits in MEM
        begin_load(50);
        prog_q = '{16'h7000, 16'h0055, 16'hB000, 16'h0086, 16'hF000};
        load_prog(16'h0000);
        poke(16'h0086, 16'h0000);
        rst_n = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_we) break;
        end
        check("p8_store_wait", bus.mem_we, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("p8_req", bus.mem_req, 0);
        check("p8_we", bus.mem_we, 0);
        check("p8_pc", dbg_pc, 16'h0000);
        check("p8_halted", halted, 0);
        check("p8_no_write", mem[16'h0086], 16'h0000);

        // r0 must be cleared by that reset
        begin_load(0);
        prog_q = '{16'hB000, 16'h0087, 16'hF000};
        load_prog(16'h0000);
        exp_q.push_back('{a: 16'h0087, d: 16'h0000});
        run_to_halt(200, hcnt);
        check("p9_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
